sha256_stream: RTL and testbench

Streaming SHA-256 engine for arbitrary-length messages. It accepts 32-bit words over a valid/ready handshake, inserts FIPS 180-4 padding and the length field in hardware, and chains compression across any number of 512-bit blocks. It sits between the AXI/DMA word source and the digest register bank. It supersedes the single-block, host-padded hashing path.

---
 rtl/sha256_pkg.sv | 66 ++++++
 rtl/sha256_pad.sv | 111 +++++++++++
 rtl/sha256_stream.sv | 170 +++++++++++++++++
 tb/tb_sha256_stream.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 round constants, initial hash values, FSM encoding and round functions
// used by sha256_stream and sha256_pad.
package sha256_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, PAD, ROUND, ADD, DONE} state_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] IV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                      input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_pad.sv
// Message word source for the W register: tracks the word index within a block, places the
// 0x80 marker, emits the 64-bit bit-length words and decides when a second padding block is owed.
module sha256_pad
   import sha256_pkg::*;
#(
   parameter int LEN_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  state_t      state_i,
   input  logic        accept_i,
   input  logic [31:0] data_i,
   input  logic        last_i,
   input  logic [2:0]  nbytes_i,
   output logic [31:0] word_o,
   output logic        we_o,
   output logic        blockEnd_o,
   output logic        ended_o,
   output logic        lenDone_o
);

   logic [3:0]       idx_q, idx_d, wrIdx;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             mark_q, mark_d;
   logic             ended_q, ended_d;
   logic             lenHi_q, lenHi_d;
   logic             lenDone_q, lenDone_d;
   logic [63:0]      lenBits;

   assign lenBits   = {{(61-LEN_W){1'b0}}, cnt_q, 3'b000};
   assign ended_o   = ended_q;
   assign lenDone_o = lenDone_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         cnt_q     <= '0;
         mark_q    <= 1'b0;
         ended_q   <= 1'b0;
         lenHi_q   <= 1'b0;
         lenDone_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         mark_q    <= mark_d;
         ended_q   <= ended_d;
         lenHi_q   <= lenHi_d;
         lenDone_q <= lenDone_d;
      end
   end

   // IDLE clears the message context first so the accepting handshake builds on a fresh start.
   always_comb begin
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      mark_d    = mark_q;
      ended_d   = ended_q;
      lenHi_d   = lenHi_q;
      lenDone_d = lenDone_q;
      word_o    = '0;
      we_o      = 1'b0;
      if (state_i == IDLE) begin
         idx_d     = '0;
         cnt_d     = '0;
         mark_d    = 1'b0;
         ended_d   = 1'b0;
         lenHi_d   = 1'b0;
         lenDone_d = 1'b0;
      end
      wrIdx = idx_d;
      if (accept_i) begin
         we_o = 1'b1;
         if (last_i) begin
            ended_d = 1'b1;
            cnt_d   = cnt_d + LEN_W'(nbytes_i);
            unique case (nbytes_i)
               3'd0:    word_o = 32'h8000_0000;
               3'd1:    word_o = {data_i[31:24], 24'h80_0000};
               3'd2:    word_o = {data_i[31:16], 16'h8000};
               3'd3:    word_o = {data_i[31:8], 8'h80};
               default: begin
                  word_o = data_i;
                  mark_d = 1'b1;
               end
            endcase
         end else begin
            word_o = data_i;
            cnt_d  = cnt_d + LEN_W'(4);
         end
      end else if (state_i == PAD) begin
         we_o = 1'b1;
         // Length fits only when word 14 is still free after the marker; else this block is zero-filled.
         if (mark_q) begin
            word_o = 32'h8000_0000;
            mark_d = 1'b0;
         end else if (wrIdx == 4'd14) begin
            word_o  = lenBits[63:32];
            lenHi_d = 1'b1;
         end else if (wrIdx == 4'd15 && lenHi_q) begin
            word_o    = lenBits[31:0];
            lenHi_d   = 1'b0;
            lenDone_d = 1'b1;
         end
      end
      if (we_o) begin
         idx_d = wrIdx + 4'd1;
      end
      blockEnd_o = we_o && (wrIdx == 4'd15);
   end

endmodule

// File: rtl/sha256_stream.sv
// Streaming SHA-256 engine with hardware padding and multi-block chaining.
// Define SHA256_STREAM_SHA224_EN to add the mode224 port and SHA-224 support.
module sha256_stream
   import sha256_pkg::*;
#(
   parameter bit BSWAP = 1'b1,
   parameter int LEN_W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   input  logic         s_last,
   input  logic [1:0]   s_bytes,
   input  logic         s_full,
`ifdef SHA256_STREAM_SHA224_EN
   input  logic         mode224,
`endif
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         busy
);

   state_t       state_q, state_d;
   logic [31:0]  w_q [16];
   logic [31:0]  w_d [16];
   logic [31:0]  v_q [8];
   logic [31:0]  v_d [8];
   logic [31:0]  hash_q [8];
   logic [31:0]  hash_d [8];
   logic [31:0]  sumH [8];
   logic [5:0]   round_q, round_d;
   logic [255:0] digest_q, digest_d;
   logic         mode_q, mode_d;
   logic         accept, modeIn;
   logic [31:0]  dataSw, t1, t2, wNew, padWord;
   logic [2:0]   nbytes;
   logic         padWe, blockEnd, msgEnded, lenDone;

`ifdef SHA256_STREAM_SHA224_EN
   assign modeIn = mode224;
`else
   assign modeIn = 1'b0;
`endif

   assign s_ready      = (state_q == IDLE) || (state_q == LOAD);
   assign accept       = s_valid && s_ready;
   assign busy         = (state_q != IDLE) && (state_q != DONE);
   assign digest_valid = (state_q == DONE);
   assign digest       = digest_q;
   assign nbytes       = s_full ? 3'd4 : {1'b0, s_bytes};
   assign dataSw       = BSWAP ? {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]} : s_data;

   sha256_pad #(.LEN_W(LEN_W)) u_pad (
      .clk       (clk),
      .rst_n     (rst_n),
      .state_i   (state_q),
      .accept_i  (accept),
      .data_i    (dataSw),
      .last_i    (s_last),
      .nbytes_i  (nbytes),
      .word_o    (padWord),
      .we_o      (padWe),
      .blockEnd_o(blockEnd),
      .ended_o   (msgEnded),
      .lenDone_o (lenDone)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         w_q      <= '{default: '0};
         v_q      <= '{default: '0};
         hash_q   <= '{default: '0};
         round_q  <= '0;
         digest_q <= '0;
         mode_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         w_q      <= w_d;
         v_q      <= v_d;
         hash_q   <= hash_d;
         round_q  <= round_d;
         digest_q <= digest_d;
         mode_q   <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = s_last ? PAD : LOAD;
         LOAD: begin
            if (accept) begin
               if (blockEnd)    state_d = ROUND;
               else if (s_last) state_d = PAD;
            end
         end
         PAD:     if (blockEnd) state_d = ROUND;
         ROUND:   if (round_q == 6'd63) state_d = ADD;
         ADD: begin
            if (!msgEnded)     state_d = LOAD;
            else if (!lenDone) state_d = PAD;
            else               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // W[t] always sits in w_q[0]; during ROUND the schedule word W[t+16] is appended at the tail.
   always_comb begin
      w_d      = w_q;
      v_d      = v_q;
      hash_d   = hash_q;
      round_d  = round_q;
      digest_d = digest_q;
      mode_d   = mode_q;
      t1   = v_q[7] + bsig1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + K[round_q] + w_q[0];
      t2   = bsig0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
      wNew = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
      for (int i = 0; i < 8; i++) begin
         sumH[i] = hash_q[i] + v_q[i];
      end
      unique case (state_q)
         IDLE: begin
            for (int i = 0; i < 8; i++) begin
               hash_d[i] = modeIn ? IV224[i] : IV256[i];
            end
            if (accept) mode_d = modeIn;
         end
         ROUND: begin
            v_d[0] = t1 + t2;
            v_d[1] = v_q[0];
            v_d[2] = v_q[1];
            v_d[3] = v_q[2];
            v_d[4] = v_q[3] + t1;
            v_d[5] = v_q[4];
            v_d[6] = v_q[5];
            v_d[7] = v_q[6];
            for (int i = 0; i < 15; i++) begin
               w_d[i] = w_q[i+1];
            end
            w_d[15] = wNew;
            round_d = round_q + 6'd1;
         end
         ADD: begin
            hash_d = sumH;
            if (state_d == DONE) begin
               digest_d = {sumH[0], sumH[1], sumH[2], sumH[3], sumH[4], sumH[5], sumH[6],
                           mode_q ? 32'h0 : sumH[7]};
            end
         end
         default: ;
      endcase
      if (padWe) begin
         for (int i = 0; i < 15; i++) begin
            w_d[i] = w_q[i+1];
         end
         w_d[15] = padWord;
      end
      // Working variables restart from the chained hash at the start of every block.
      if (state_d == ROUND && state_q != ROUND) begin
         v_d     = hash_q;
         round_d = '0;
      end
   end

endmodule

// File: tb/tb_sha256_stream.sv
// Directed self-checking bench for sha256_stream using known FIPS 180-4 digests.
// Adds the SHA-224 case when SHA256_STREAM_SHA224_EN is defined.
module tb_sha256_stream;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         s_valid;
   logic         s_ready;
   logic [31:0]  s_data;
   logic         s_last;
   logic [1:0]   s_bytes;
   logic         s_full;
`ifdef SHA256_STREAM_SHA224_EN
   logic         mode224;
`endif
   logic [255:0] digest;
   logic         digest_valid;
   logic         busy;

   int testCount = 0;
   int failCount = 0;

   logic [255:0] expAbc   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   logic [255:0] expEmpty = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   logic [255:0] expMsg56 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   logic [255:0] expA     = 256'hca978112_ca1bbdca_fac231b3_9a23dc4d_a786eff8_147c4e72_b9807785_afee48bb;
`ifdef SHA256_STREAM_SHA224_EN
   logic [255:0] exp224   = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
`endif

   always #5 clk = ~clk;

   sha256_stream #(.BSWAP(1'b1), .LEN_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_bytes     (s_bytes),
      .s_full      (s_full),
`ifdef SHA256_STREAM_SHA224_EN
      .mode224     (mode224),
`endif
      .digest      (digest),
      .digest_valid(digest_valid),
      .busy        (busy)
   );

   function automatic logic [31:0] toLane(input logic [31:0] be);
      return {be[7:0], be[15:8], be[23:16], be[31:24]};
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Called between clock edges; returns #1 after the posedge on which the word was accepted.
   task automatic applyStimulus(input logic [31:0] data, input logic last,
                                input logic [1:0] nb, input logic full);
      int guard;
      s_data  = data;
      s_last  = last;
      s_bytes = nb;
      s_full  = full;
      s_valid = 1'b1;
      guard   = 0;
      while (!s_ready && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checkOutput("s_ready wait", s_ready, 1'b1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_full  = 1'b0;
      s_bytes = 2'd0;
   endtask

   task automatic waitDigest(output int cycles, output int readyHigh);
      cycles    = 0;
      readyHigh = 0;
      do begin
         @(negedge clk);
         cycles++;
         if (s_ready) readyHigh++;
      end while (!digest_valid && cycles < 400);
      checkOutput("digest_valid timeout", digest_valid, 1'b1);
   endtask

   task automatic sendMsg56(input bit gaps);
      logic [7:0] c;
      for (int i = 0; i < 14; i++) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
         c = 8'h61 + 8'(i);
         applyStimulus(toLane({c, c + 8'd1, c + 8'd2, c + 8'd3}), i == 13, 2'd0, i == 13);
      end
   endtask

   initial begin
      int cycles;
      int readyHigh;
      int seen;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      s_bytes = 2'd0;
      s_full  = 1'b0;
`ifdef SHA256_STREAM_SHA224_EN
      mode224 = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checkOutput("reset digest", digest, '0);
      checkOutput("reset digest_valid", digest_valid, 1'b0);
      checkOutput("reset busy", busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle s_ready", s_ready, 1'b1);

      $display("[TB] abc single-block message");
      applyStimulus(toLane(32'h61626300), 1'b1, 2'd3, 1'b0);
      checkOutput("busy after first word", busy, 1'b1);
      waitDigest(cycles, readyHigh);
      checkOutput("abc digest", digest, expAbc);
      checkOutput("abc latency", cycles, 81);
      checkOutput("abc s_ready low while hashing", readyHigh, 0);
      @(negedge clk);
      checkOutput("digest_valid single pulse", digest_valid, 1'b0);
      repeat (5) @(negedge clk);
      checkOutput("abc digest held", digest, expAbc);

      $display("[TB] empty message");
      applyStimulus(32'h0, 1'b1, 2'd0, 1'b0);
      waitDigest(cycles, readyHigh);
      checkOutput("empty digest", digest, expEmpty);
      checkOutput("empty latency", cycles, 81);

      $display("[TB] one-byte message");
      @(negedge clk);
      applyStimulus(toLane(32'h61000000), 1'b1, 2'd1, 1'b0);
      waitDigest(cycles, readyHigh);
      checkOutput("a digest", digest, expA);

      $display("[TB] 56-byte two-block padding");
      @(negedge clk);
      sendMsg56(1'b0);
      waitDigest(cycles, readyHigh);
      checkOutput("msg56 digest", digest, expMsg56);

      $display("[TB] 56-byte message with input gaps");
      @(negedge clk);
      sendMsg56(1'b1);
      waitDigest(cycles, readyHigh);
      checkOutput("msg56 gapped digest", digest, expMsg56);
      checkOutput("msg56 s_ready low while hashing", readyHigh, 0);

      $display("[TB] reset during ROUND then abc");
      @(negedge clk);
      sendMsg56(1'b0);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("mid-reset digest cleared", digest, '0);
      checkOutput("mid-reset digest_valid", digest_valid, 1'b0);
      rst_n = 1'b1;
      seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (digest_valid) seen++;
      end
      checkOutput("no digest_valid from aborted message", seen, 0);
      checkOutput("idle after abort", s_ready, 1'b1);
      applyStimulus(toLane(32'h61626300), 1'b1, 2'd3, 1'b0);
      waitDigest(cycles, readyHigh);
      checkOutput("abc after reset digest", digest, expAbc);

`ifdef SHA256_STREAM_SHA224_EN
      $display("[TB] SHA-224 abc");
      @(negedge clk);
      mode224 = 1'b1;
      applyStimulus(toLane(32'h61626300), 1'b1, 2'd3, 1'b0);
      mode224 = 1'b0;
      waitDigest(cycles, readyHigh);
      checkOutput("sha224 abc digest", digest, exp224);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
